// File: rtl/probe_helper_mc.sv
// probe_helper_mc
//   Watches directory results for Acquire requests that conflict with lines
//   held by other clients, queues the resulting probes in a DEPTH-entry
//   circular FIFO, and offers the head entry to the request arbiter.
//   Requests to an address already queued are folded into that entry's mask.
//
// Optional feature: define PROBE_HELPER_MC_PERF_EN to add the wrapping 32-bit
// counters perf_enq / perf_merge / perf_drop.
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   dir_valid             directory result valid (one cycle, no backpressure)
//   dir_states/dir_hits   per-client state (2 bits each) and hit
//   dir_tag_match         client-directory tag match
//   dir_tag/dir_set       victim tag and request set
//   dir_source            request source id
//   dir_channel/opcode    replacer-info channel and opcode
//   probe_ready           arbiter accepts the head entry
//   probe_valid/source/set/tag/client_mask   head entry
//   io_full               occupancy >= FULL_THRESH
//   count                 occupancy
//   overflow              sticky: a required probe was dropped
module probe_helper_mc #(
  parameter int N_CLIENTS   = 2,
  parameter int DEPTH       = 4,
  parameter int FULL_THRESH = 3,
  parameter int CTAG_W      = 23,
  parameter int CSET_W      = 7,
  parameter int SET_W       = 10,
  parameter int SRC_W       = 6,
  localparam int PTAG_W     = CTAG_W + CSET_W - SET_W,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   dir_valid,
  input  logic [2*N_CLIENTS-1:0] dir_states,
  input  logic [N_CLIENTS-1:0]   dir_hits,
  input  logic                   dir_tag_match,
  input  logic [CTAG_W-1:0]      dir_tag,
  input  logic [SET_W-1:0]       dir_set,
  input  logic [SRC_W-1:0]       dir_source,
  input  logic [2:0]             dir_channel,
  input  logic [2:0]             dir_opcode,
  input  logic                   probe_ready,
  output logic                   probe_valid,
  output logic [SRC_W-1:0]       probe_source,
  output logic [SET_W-1:0]       probe_set,
  output logic [PTAG_W-1:0]      probe_tag,
  output logic [N_CLIENTS-1:0]   probe_client_mask,
  output logic                   io_full,
  output logic [CNT_W-1:0]       count,
`ifdef PROBE_HELPER_MC_PERF_EN
  output logic [31:0]            perf_enq,
  output logic [31:0]            perf_merge,
  output logic [31:0]            perf_drop,
`endif
  output logic                   overflow
);

  localparam int ADDR_W = CTAG_W + CSET_W;
  localparam int PTR_W  = $clog2(DEPTH);

  logic [SRC_W-1:0]     src_q  [DEPTH];
  logic [SET_W-1:0]     set_q  [DEPTH];
  logic [PTAG_W-1:0]    tag_q  [DEPTH];
  logic [N_CLIENTS-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q;

  logic [N_CLIENTS-1:0] conflict;
  logic                 need;
  logic [ADDR_W-1:0]    addr;
  logic [SET_W-1:0]     new_set;
  logic [PTAG_W-1:0]    new_tag;
  logic                 deq, hit, merge, enq, drop;
  logic [PTR_W-1:0]     hit_idx;
  logic [SET_W-1:0]     unused_dir_set;

  // Only the low CSET_W bits of dir_set form part of the address.
  assign unused_dir_set = dir_set;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    conflict = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      conflict[i] = ~dir_hits[i] & (|dir_states[2*i +: 2]);
  end

  assign need = dir_valid & ~dir_tag_match & (|conflict) & (dir_channel == 3'd1) &
                ((dir_opcode == 3'd6) | (dir_opcode == 3'd7));

  assign addr    = {dir_tag, dir_set[CSET_W-1:0]};
  assign new_set = addr[SET_W-1:0];
  assign new_tag = addr[ADDR_W-1:SET_W];

  assign probe_valid = vld_q[head_q];
  assign deq         = probe_valid & probe_ready;

  // The head is never a merge target: whenever it is valid it is being
  // offered, so it is either leaving this cycle or must be held stable.
  // A request matching only the head therefore becomes a fresh entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && vld_q[i] && (PTR_W'(i) != head_q) &&
          (set_q[i] == new_set) && (tag_q[i] == new_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign merge = need & hit;
  assign enq   = need & ~hit & ((count_q != CNT_W'(DEPTH)) | deq);
  assign drop  = need & ~hit & (count_q == CNT_W'(DEPTH)) & ~deq;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        src_q[i]  <= '0;
        set_q[i]  <= '0;
        tag_q[i]  <= '0;
        mask_q[i] <= '0;
      end
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= next_ptr(head_q);
      end
      // When full with a dequeue, tail == head; this later write wins.
      if (enq) begin
        src_q[tail_q]  <= dir_source;
        set_q[tail_q]  <= new_set;
        tag_q[tail_q]  <= new_tag;
        mask_q[tail_q] <= conflict;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= next_ptr(tail_q);
      end
      if (merge)
        mask_q[hit_idx] <= mask_q[hit_idx] | conflict;
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop)
        overflow_q <= 1'b1;
    end
  end

  assign probe_source      = probe_valid ? src_q[head_q]  : '0;
  assign probe_set         = probe_valid ? set_q[head_q]  : '0;
  assign probe_tag         = probe_valid ? tag_q[head_q]  : '0;
  assign probe_client_mask = probe_valid ? mask_q[head_q] : '0;
  assign count             = count_q;
  assign io_full           = (count_q >= CNT_W'(FULL_THRESH));
  assign overflow          = overflow_q;

`ifdef PROBE_HELPER_MC_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_enq   <= '0;
      perf_merge <= '0;
      perf_drop  <= '0;
    end else begin
      if (enq)   perf_enq   <= perf_enq + 32'd1;
      if (merge) perf_merge <= perf_merge + 32'd1;
      if (drop)  perf_drop  <= perf_drop + 32'd1;
    end
  end
`endif

endmodule
